// File: rtl/bus_sel_arb.sv
// Registered N-channel valid/ready bus selector with explicit-select and arbitration modes.
// Define BUS_SEL_ARB_RR_EN for round-robin arbitration; otherwise fixed priority (lowest index).
module bus_sel_arb #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic                      force_sel,
  input  logic [SEL_W-1:0]          sel,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_chan,
  output logic                      out_valid,
  input  logic                      out_ready
);

  logic [WIDTH-1:0] out_data_r;
  logic [SEL_W-1:0] out_chan_r;
  logic             out_valid_r;
  logic [SEL_W-1:0] grant_s;
  logic             granted_s;
  logic             can_load_s;
  logic             load_s;
`ifdef BUS_SEL_ARB_RR_EN
  logic [SEL_W-1:0] last_r;
  logic [SEL_W-1:0] cand_s;
`endif

  assign can_load_s = !out_valid_r || out_ready;
  assign load_s     = can_load_s && granted_s;

  // Grant selection: explicit select, or arbitration among valid channels.
  always_comb begin
    grant_s   = '0;
    granted_s = 1'b0;
`ifdef BUS_SEL_ARB_RR_EN
    cand_s    = '0;
`endif
    if (force_sel) begin
      if ((int'(sel) < CHANNELS) && in_valid[sel]) begin
        grant_s   = sel;
        granted_s = 1'b1;
      end else begin
        grant_s   = '0;
        granted_s = 1'b0;
      end
    end else begin
`ifdef BUS_SEL_ARB_RR_EN
      // Walk the search order backwards so the closest channel after last wins.
      for (int k = CHANNELS; k >= 1; k--) begin
        cand_s    = SEL_W'((int'(last_r) + k) % CHANNELS);
        granted_s = granted_s | in_valid[cand_s];
        grant_s   = in_valid[cand_s] ? cand_s : grant_s;
      end
`else
      for (int k = CHANNELS - 1; k >= 0; k--) begin
        granted_s = granted_s | in_valid[k];
        grant_s   = in_valid[k] ? SEL_W'(k) : grant_s;
      end
`endif
    end
  end

  // One-hot accept toward the granted producer, suppressed while in reset.
  always_comb begin
    if (rst_n && load_s) begin
      in_ready = {{(CHANNELS-1){1'b0}}, 1'b1} << grant_s;
    end else begin
      in_ready = '0;
    end
  end

  // Output register stage: load replaces, drain clears valid, stall holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_r  <= '0;
      out_chan_r  <= '0;
      out_valid_r <= 1'b0;
    end else if (load_s) begin
      out_data_r  <= in_data[int'(grant_s)*WIDTH +: WIDTH];
      out_chan_r  <= grant_s;
      out_valid_r <= 1'b1;
    end else if (out_ready) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

`ifdef BUS_SEL_ARB_RR_EN
  // Round-robin pointer; reset value makes channel 0 the first choice.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_r <= SEL_W'(CHANNELS - 1);
    end else if (load_s) begin
      last_r <= grant_s;
    end else begin
      last_r <= last_r;
    end
  end
`endif

  assign out_data  = out_data_r;
  assign out_chan  = out_chan_r;
  assign out_valid = out_valid_r;

endmodule

// File: tb/tb_bus_sel_arb.sv
// Self-checking bench for bus_sel_arb: directed scenarios plus randomized traffic
// checked against a transaction-level reference model.
module tb_bus_sel_arb;
  localparam int CH = 4;
  localparam int W  = 8;
  localparam int SW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [CH*W-1:0] in_data;
  logic [CH-1:0] in_valid;
  logic [CH-1:0] in_ready;
  logic          force_sel;
  logic [SW-1:0] sel;
  logic [W-1:0]  out_data;
  logic [SW-1:0] out_chan;
  logic          out_valid;
  logic          out_ready;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  bit       m_valid;
  bit [7:0] m_data;
  int       m_chan;
  int       m_last;

  bus_sel_arb #(.WIDTH(W), .CHANNELS(CH)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .force_sel(force_sel), .sel(sel),
    .out_data(out_data), .out_chan(out_chan), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_valid = 1'b0;
    m_data  = 8'h00;
    m_chan  = 0;
    m_last  = CH - 1;
  endfunction

  // Which channel the rules say should be granted now, or -1.
  function automatic int exp_grant();
    if (force_sel) begin
      return (int'(sel) < CH && in_valid[sel]) ? int'(sel) : -1;
    end
`ifdef BUS_SEL_ARB_RR_EN
    for (int k = 1; k <= CH; k++) begin
      if (in_valid[(m_last + k) % CH]) return (m_last + k) % CH;
    end
`else
    for (int c = 0; c < CH; c++) begin
      if (in_valid[c]) return c;
    end
`endif
    return -1;
  endfunction

  // One clock: check accepts mid-cycle, advance model at the edge, check outputs after.
  task automatic tick();
    int g;
    logic [CH-1:0] er;
    @(negedge clk);
    g  = exp_grant();
    er = (rst_n && (!m_valid || out_ready) && g >= 0) ? (4'b0001 << g) : 4'b0000;
    check_eq("in_ready", {28'd0, in_ready}, {28'd0, er});
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else if (er != 4'b0000) begin
      m_valid = 1'b1;
      m_data  = in_data[g*W +: W];
      m_chan  = g;
      m_last  = g;
    end else if (m_valid && out_ready) begin
      m_valid = 1'b0;
    end
    #1;
    check_eq("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
    check_eq("out_data", {24'd0, out_data}, {24'd0, m_data});
    check_eq("out_chan", {30'd0, out_chan}, 32'(m_chan));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    in_valid = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  int exp_seq[5];

  initial begin
    rst_n = 1'b0; in_data = 32'h13121110; in_valid = 4'b1111;
    force_sel = 1'b0; sel = 2'd0; out_ready = 1'b1;
    model_reset();

    // Reset and idle
    #2;
    check_eq("rst_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_data", {24'd0, out_data}, 32'd0);
    tick();
    tick();
    do_reset();
    for (int i = 0; i < 10; i++) tick();

    // Explicit select
    force_sel = 1'b1; sel = 2'd2; in_valid = 4'b1111; in_data = 32'h11A5_2233;
    tick();
    check_eq("sel_data", {24'd0, out_data}, 32'h0000_00A5);
    check_eq("sel_chan", {30'd0, out_chan}, 32'd2);
    in_valid = 4'b1011;
    tick();
    check_eq("sel_nogrant", {31'd0, out_valid}, 32'd0);

    // Back-pressure and back-to-back
    sel = 2'd0; in_valid = 4'b0001; in_data = 32'h0000_003C;
    tick();
    out_ready = 1'b0; in_valid = 4'b1111; in_data = 32'hDEAD_BE3C;
    for (int i = 0; i < 5; i++) tick();
    check_eq("stall_data", {24'd0, out_data}, 32'h0000_003C);
    out_ready = 1'b1; in_data = 32'h0102_0304;
    for (int i = 0; i < 3; i++) begin
      in_data[7:0] = 8'(8'h40 + i);
      tick();
      check_eq("b2b_valid", {31'd0, out_valid}, 32'd1);
    end

    // Arbitration sequences from a fresh reset
    do_reset();
    force_sel = 1'b0; in_valid = 4'b1111; in_data = 32'h1312_1110; out_ready = 1'b1;
`ifdef BUS_SEL_ARB_RR_EN
    exp_seq = '{0, 1, 2, 3, 0};
`else
    exp_seq = '{0, 0, 0, 0, 0};
`endif
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("arb_all", {30'd0, out_chan}, 32'(exp_seq[i]));
    end
    in_valid = 4'b1010;
`ifdef BUS_SEL_ARB_RR_EN
    exp_seq = '{1, 3, 1, 3, 1};
`else
    exp_seq = '{1, 1, 1, 1, 1};
`endif
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("arb_13", {30'd0, out_chan}, 32'(exp_seq[i]));
    end

    // Async reset while a word is stalled
    force_sel = 1'b1; sel = 2'd1; in_valid = 4'b0010; in_data = 32'h0000_7700;
    tick();
    out_ready = 1'b0;
    tick();
    tick();
    check_eq("stall77", {24'd0, out_data}, 32'h0000_0077);
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_valid", {31'd0, out_valid}, 32'd0);
    check_eq("async_data", {24'd0, out_data}, 32'd0);
    model_reset();
    tick();
    in_valid = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
    force_sel = 1'b0; in_valid = 4'b1111; out_ready = 1'b1; in_data = 32'h1312_1110;
    tick();
    check_eq("post_rst_chan", {30'd0, out_chan}, 32'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      in_data   = $urandom;
      in_valid  = 4'($urandom);
      force_sel = ($urandom_range(0, 3) == 0);
      sel       = 2'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
